// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host-side bundle of the queued UART transmitter.
//   master (host) drives : load_i, datai_i, stop2_i, par_en_i, par_odd_i
//   slave  (tx)   drives : busy_o, wip_o, count_o, overrun_o
// Parameters DATA_W / FIFO_AW must match the attached uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 2
);
  logic              load_i;
  logic [DATA_W-1:0] datai_i;
  logic              stop2_i;
  logic              par_en_i;
  logic              par_odd_i;
  logic              busy_o;
  logic              wip_o;
  logic [FIFO_AW:0]  count_o;
  logic              overrun_o;

  modport master (
    output load_i, datai_i, stop2_i, par_en_i, par_odd_i,
    input  busy_o, wip_o, count_o, overrun_o
  );

  modport slave (
    input  load_i, datai_i, stop2_i, par_en_i, par_odd_i,
    output busy_o, wip_o, count_o, overrun_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: RS-232 transmitter with a 2**FIFO_AW-entry write queue.
//   clk_i     single clock
//   reset_i   synchronous reset, active high
//   enable_i  bit-time tick from the baud divider, one cycle wide
//   host      uart_tx_fifo_if.slave: load/data/frame config in,
//             busy/wip/count/overrun status out
//   txd_o     serial output, idle high, registered
// Frame: [idle/stop tick] start, DATA_W bits LSB first, [parity], [stop2].
// Build option: define UART_TX_PARITY_EN to include the parity state;
// without it par_en_i / par_odd_i are ignored.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high (stop bit); pops next entry on a tick if queued
// ST_START | drives start bit
// ST_DATA  | shifts out DATA_W bits, LSB first
// ST_PARITY| drives parity bit (UART_TX_PARITY_EN only)
// ST_STOP2 | drives the second stop bit
module uart_tx_fifo #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 2
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           enable_i,
  uart_tx_fifo_if.slave  host,
  output logic           txd_o
);

  localparam int                 DEPTH    = 2 ** FIFO_AW;
  localparam int                 CNT_W    = FIFO_AW + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [3:0]         LAST_BIT = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP2
`ifdef UART_TX_PARITY_EN
    , ST_PARITY
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                txd_q, txd_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                stop2_lat_q, stop2_lat_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                push, pop, full;

`ifdef UART_TX_PARITY_EN
  logic par_acc_q, par_acc_d;
  logic par_en_lat_q, par_en_lat_d;
  logic par_odd_lat_q, par_odd_lat_d;
`else
  logic unused_par;
  assign unused_par = host.par_en_i ^ host.par_odd_i;
`endif

  always_comb begin
    full = (count_q == DEPTH_C);
    pop  = enable_i && (state_q == ST_IDLE) && (count_q != '0);
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    push = host.load_i && (!full || pop);

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    txd_d       = txd_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop2_lat_d = stop2_lat_q;
`ifdef UART_TX_PARITY_EN
    par_acc_d     = par_acc_q;
    par_en_lat_d  = par_en_lat_q;
    par_odd_lat_d = par_odd_lat_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = host.datai_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    busy_d    = (count_d == DEPTH_C);
    overrun_d = host.load_i && !push;

    if (enable_i) begin
      case (state_q)
        ST_IDLE: begin
          txd_d = 1'b1;
          if (pop) begin
            shift_d     = mem_q[rd_ptr_q];
            stop2_lat_d = host.stop2_i;
`ifdef UART_TX_PARITY_EN
            par_en_lat_d  = host.par_en_i;
            par_odd_lat_d = host.par_odd_i;
            par_acc_d     = 1'b0;
`endif
            state_d = ST_START;
          end
        end
        ST_START: begin
          txd_d     = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef UART_TX_PARITY_EN
          par_acc_d = par_acc_q ^ shift_q[0];
`endif
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_lat_q)     state_d = ST_PARITY;
            else if (stop2_lat_q) state_d = ST_STOP2;
            else                  state_d = ST_IDLE;
`else
            state_d = stop2_lat_q ? ST_STOP2 : ST_IDLE;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          txd_d   = par_acc_q ^ par_odd_lat_q;
          state_d = stop2_lat_q ? ST_STOP2 : ST_IDLE;
        end
`endif
        ST_STOP2: begin
          txd_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          txd_d   = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // storage carries no reset; pointers and count define what is valid
    mem_q <= mem_d;
    if (reset_i) begin
      state_q     <= ST_IDLE;
      txd_q       <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop2_lat_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_acc_q     <= 1'b0;
      par_en_lat_q  <= 1'b0;
      par_odd_lat_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      txd_q       <= txd_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop2_lat_q <= stop2_lat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
`ifdef UART_TX_PARITY_EN
      par_acc_q     <= par_acc_d;
      par_en_lat_q  <= par_en_lat_d;
      par_odd_lat_q <= par_odd_lat_d;
`endif
    end
  end

  assign txd_o          = txd_q;
  assign host.busy_o    = busy_q;
  assign host.count_o   = count_q;
  assign host.overrun_o = overrun_q;
  assign host.wip_o     = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en8 = 1'b0;
  logic en5 = 1'b0;
  logic txd8, txd5;

  int n_tests = 0;
  int n_fail  = 0;

  logic q8[$];
  logic q5[$];
  int   tick_no8 = 0;
  int   tick_no5 = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_W(8), .FIFO_AW(2)) h8 ();
  uart_tx_fifo_if #(.DATA_W(5), .FIFO_AW(2)) h5 ();

  uart_tx_fifo #(.DATA_W(8), .FIFO_AW(2)) dut8 (
    .clk_i(clk), .reset_i(rst), .enable_i(en8), .host(h8), .txd_o(txd8)
  );
  uart_tx_fifo #(.DATA_W(5), .FIFO_AW(2)) dut5 (
    .clk_i(clk), .reset_i(rst), .enable_i(en5), .host(h5), .txd_o(txd5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitors: every enable tick consumes one expected txd bit,
  // or expects the idle level when nothing is outstanding
  initial forever begin
    logic e;
    @(posedge clk);
    if (en8) begin
      #1;
      tick_no8++;
      e = (q8.size() != 0) ? q8.pop_front() : 1'b1;
      check($sformatf("txd8_tick%0d", tick_no8), 32'(txd8), 32'(e));
    end
  end

  initial forever begin
    logic e;
    @(posedge clk);
    if (en5) begin
      #1;
      tick_no5++;
      e = (q5.size() != 0) ? q5.pop_front() : 1'b1;
      check($sformatf("txd5_tick%0d", tick_no5), 32'(txd5), 32'(e));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick8();
    @(negedge clk) en8 = 1'b1;
    @(negedge clk) en8 = 1'b0;
  endtask

  task automatic tick5();
    @(negedge clk) en5 = 1'b1;
    @(negedge clk) en5 = 1'b0;
  endtask

  task automatic load8(input logic [7:0] d);
    @(negedge clk) begin h8.load_i = 1'b1; h8.datai_i = d; end
    @(negedge clk) h8.load_i = 1'b0;
  endtask

  task automatic push_bits8(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) q8.push_back(bits[n-1-i]);
  endtask

  // expected frame: idle/pop tick, start, data LSB first, parity, stop2
  task automatic push_frame8(input logic [7:0] d, input logic s2,
                             input logic has_par, input logic par_bit);
    q8.push_back(1'b1);
    q8.push_back(1'b0);
    for (int i = 0; i < 8; i++) q8.push_back(d[i]);
    if (has_par) q8.push_back(par_bit);
    if (s2) q8.push_back(1'b1);
  endtask

  task automatic drain8(input string name);
    int n = 0;
    while (q8.size() != 0 && n < 200) begin
      tick8();
      n++;
    end
    check({name, "_drain_bounded"}, 32'(n < 200), 32'd1);
    tick8();
  endtask

  initial begin
    h8.load_i = 1'b0; h8.datai_i = '0; h8.stop2_i = 1'b0;
    h8.par_en_i = 1'b0; h8.par_odd_i = 1'b0;
    h5.load_i = 1'b0; h5.datai_i = '0; h5.stop2_i = 1'b0;
    h5.par_en_i = 1'b0; h5.par_odd_i = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_txd",     32'(txd8),         32'd1);
    check("rst_busy",    32'(h8.busy_o),    32'd0);
    check("rst_wip",     32'(h8.wip_o),     32'd0);
    check("rst_count",   32'(h8.count_o),   32'd0);
    check("rst_overrun", 32'(h8.overrun_o), 32'd0);
    check("rst_txd5",    32'(txd5),         32'd1);

    // 1: 8N1, 0x55
    load8(8'h55);
    check("t1_count", 32'(h8.count_o), 32'd1);
    check("t1_wip",   32'(h8.wip_o),   32'd1);
    push_bits8(16'b1010101010, 10);
    repeat (5) tick8();
    check("t1_wip_mid", 32'(h8.wip_o), 32'd1);
    repeat (6) tick8();
    check("t1_wip_end",   32'(h8.wip_o),   32'd0);
    check("t1_count_end", 32'(h8.count_o), 32'd0);
    check("t1_q_empty",   32'(q8.size()),  32'd0);

    // 2: two stop bits, back-to-back frames
    h8.stop2_i = 1'b1;
    load8(8'hA5);
    load8(8'h3C);
    check("t2_count2", 32'(h8.count_o), 32'd2);
    push_frame8(8'hA5, 1'b1, 1'b0, 1'b0);
    push_frame8(8'h3C, 1'b1, 1'b0, 1'b0);
    tick8();
    check("t2_count1", 32'(h8.count_o), 32'd1);
    repeat (11) tick8();
    check("t2_count0", 32'(h8.count_o), 32'd0);
    drain8("t2");
    check("t2_wip_end", 32'(h8.wip_o), 32'd0);
    h8.stop2_i = 1'b0;

    // 3: fill, overrun, push+pop while full
    load8(8'h11); push_frame8(8'h11, 1'b0, 1'b0, 1'b0);
    load8(8'h22); push_frame8(8'h22, 1'b0, 1'b0, 1'b0);
    load8(8'h33); push_frame8(8'h33, 1'b0, 1'b0, 1'b0);
    check("t3_busy_at3", 32'(h8.busy_o), 32'd0);
    load8(8'h44); push_frame8(8'h44, 1'b0, 1'b0, 1'b0);
    check("t3_busy_at4",  32'(h8.busy_o),  32'd1);
    check("t3_count_at4", 32'(h8.count_o), 32'd4);
    load8(8'h99);
    check("t3_overrun",    32'(h8.overrun_o), 32'd1);
    check("t3_count_ovr",  32'(h8.count_o),   32'd4);
    @(negedge clk);
    check("t3_overrun_pulse", 32'(h8.overrun_o), 32'd0);
    @(negedge clk) begin h8.load_i = 1'b1; h8.datai_i = 8'h66; en8 = 1'b1; end
    @(negedge clk) begin h8.load_i = 1'b0; en8 = 1'b0; end
    push_frame8(8'h66, 1'b0, 1'b0, 1'b0);
    check("t3_count_pushpop",   32'(h8.count_o),   32'd4);
    check("t3_busy_pushpop",    32'(h8.busy_o),    32'd1);
    check("t3_overrun_pushpop", 32'(h8.overrun_o), 32'd0);
    drain8("t3");
    check("t3_count_end", 32'(h8.count_o), 32'd0);

    // 4: parity on 0x07 (three ones): even -> 1, odd -> 0
    h8.par_en_i = 1'b1; h8.par_odd_i = 1'b0;
    load8(8'h07);
    push_frame8(8'h07, 1'b0, PAR_BUILT, 1'b1);
    drain8("t4_even");
    h8.par_odd_i = 1'b1;
    load8(8'h07);
    push_frame8(8'h07, 1'b0, PAR_BUILT, 1'b0);
    drain8("t4_odd");
    h8.par_en_i = 1'b0; h8.par_odd_i = 1'b0;

    // 5: DATA_W=5, 0x1F -> 1,0,1,1,1,1,1 then idle 1
    @(negedge clk) begin h5.load_i = 1'b1; h5.datai_i = 5'h1F; end
    @(negedge clk) h5.load_i = 1'b0;
    check("t5_count", 32'(h5.count_o), 32'd1);
    q5.push_back(1'b1); q5.push_back(1'b0);
    for (int i = 0; i < 5; i++) q5.push_back(1'b1);
    repeat (8) tick5();
    check("t5_q_empty", 32'(q5.size()), 32'd0);
    check("t5_wip_end", 32'(h5.wip_o),  32'd0);

    // 6: reset mid-DATA with queued data
    load8(8'h0F); push_frame8(8'h0F, 1'b0, 1'b0, 1'b0);
    load8(8'hF0); push_frame8(8'hF0, 1'b0, 1'b0, 1'b0);
    load8(8'hC3); push_frame8(8'hC3, 1'b0, 1'b0, 1'b0);
    repeat (4) tick8();
    check("t6_wip_pre",   32'(h8.wip_o),   32'd1);
    check("t6_count_pre", 32'(h8.count_o), 32'd2);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    q8.delete();
    check("t6_txd",   32'(txd8),       32'd1);
    check("t6_count", 32'(h8.count_o), 32'd0);
    check("t6_wip",   32'(h8.wip_o),   32'd0);
    check("t6_busy",  32'(h8.busy_o),  32'd0);
    repeat (20) tick8();
    check("t6_wip_after", 32'(h8.wip_o), 32'd0);
    check("final_q_empty", 32'(q8.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
